serial_rx: RTL and testbench
============================

Name: serial_rx

Overview:
UART receiver for the serial link, the receive-side counterpart of the 8N1 serial transmitter.
- Frame format: start bit 0, 8 data bits LSB first, stop bit 1; line idles high.
- Samples asynchronous `rxd` mid-bit, assembles the byte and presents it with a valid/ack handshake.
- Reports framing and overrun errors.
- Bit rate uses the same base divisor and 2-bit mode encoding as the transmit baud generator.

Parameters:
- BAUD_DIV, 1302: clk cycles per bit at mode 0. Must be ≥ 4.
- CNT_W, 14: bit-timer width. Must hold BAUD_DIV*8-1.

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- mode  input  2  bit period = BAUD_DIV << mode clk cycles (0: x1, 1: x2, 2: x4, 3: x8)
- rxd  input  1  serial input, asynchronous to clk
- ack  input  1  consumer acknowledge; clears rx_valid and overrun
- rx_data  output  8  last correctly framed byte
- rx_valid  output  1  byte in rx_data not yet acknowledged
- frame_err  output  1  one-cycle pulse on stop-bit error
- overrun  output  1  sticky; a byte overwrote unacknowledged data
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (reset=0, asynchronous):
  - State IDLE, rx_data=8'h00, rx_valid=0, frame_err=0, overrun=0, busy=0.
  - Synchronizer flops are set to 1; bit timer and bit index are cleared.
- Input synchronization: `rxd` passes through 2 flops to give `rs`. `rs` lags `rxd` by 2 clk.
- BIT = BAUD_DIV << mode. HALF = BIT >> 1. `mode` is latched on start detection; changes mid-frame are ignored.
- IDLE:
  - When rs=0 and the previous rs=1, load timer = HALF-1 and go to START.
- START: timer decrements each clk. At timer=0, sample rs:
  - rs=0: go to DATA, timer = BIT-1, idx = 0.
  - rs=1: false start; go to IDLE with no outputs changed.
- DATA: at timer=0, sample rs.
  - Shift right: shreg = {rs, shreg[7:1]}.
  - Reload timer = BIT-1, then:
    - idx=7: go to STOP.
    - otherwise: idx+1.
- STOP: at timer=0, sample rs.
  - rs=1: rx_data <= shreg and rx_valid <= 1 in the same edge, then go to IDLE.
    - If rx_valid was already 1 and ack=0 that cycle, overrun <= 1.
  - rs=0: frame_err pulses for exactly 1 cycle. rx_data and rx_valid are unchanged. Go to WAIT_HIGH.
- WAIT_HIGH (break or line held low): stay until rs=1, then go to IDLE. No falling edge is detected while here.
- Timing: rx_valid rises 2 + HALF + 9*BIT clk after the falling edge of `rxd` (±1 clk of edge alignment).
- Handshake:
  - ack=1 with no completion in the same cycle: rx_valid <= 0 and overrun <= 0 next edge.
  - ack=1 in the same cycle as a completion: rx_valid stays 1 with the new data, overrun <= 0.
  - ack while rx_valid=0: no effect.
- Back-to-back frames: a start bit immediately following a stop bit is accepted. IDLE needs only a 1→0 transition of rs.
- Reset asserted mid-frame: immediate return to reset values; the partial byte is discarded.
- No receive-side FIFO; depth is one byte (rx_data).

Test Plan:
Run with BAUD_DIV=8.
1. Mode 0: send 0x38 with a valid stop bit → rx_data=8'h38, rx_valid=1 at 2+4+72 clk (±1) after the start edge. Then ack=1 for 1 clk → rx_valid=0.
2. Mode 2 (BIT=32): send 0x96 → rx_data=8'h96; sample points fall at 16+32k clk after the start edge. Changing mode to 0 mid-frame does not alter reception.
3. Glitch: rxd low for 3 clk in IDLE → returns to IDLE after the START sample; rx_valid stays 0; busy high for HALF clk only.
4. Framing: send 0x48 with stop bit 0 and the line held low for 40 clk → one-cycle frame_err; rx_data and rx_valid unchanged. Next frame 0x19 is received correctly after the line returns high.
5. Overrun: send 0x11 then 0x22 back-to-back with no ack → rx_data=8'h22, rx_valid=1, overrun=1; ack clears both. Repeat with ack coinciding with the second completion → overrun=0, rx_valid=1.
6. Reset: assert reset=0 during DATA bit 4 → all outputs at reset values immediately. After release, a fresh 0x5A frame is received correctly.

Source files
------------

// File: rtl/serial_rx_if.sv
// Receive-side bus of the 8N1 serial receiver: the serial line, the bit-rate mode
// and the byte handshake toward the consumer.
interface serial_rx_if;
    logic [1:0] mode;
    logic       rxd;
    logic       ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    modport master (
        output mode, rxd, ack,
        input  rx_data, rx_valid, frame_err, overrun, busy
    );

    modport slave (
        input  mode, rxd, ack,
        output rx_data, rx_valid, frame_err, overrun, busy
    );
endinterface

// File: rtl/serial_rx.sv
// 8N1 UART receiver: two-flop synchronised line, mid-bit sampling, one-byte
// holding register with valid/ack handshake, framing and overrun reporting.
module serial_rx #(
    parameter int unsigned BAUD_DIV = 1302,
    parameter int unsigned CNT_W    = 14
) (
    input  logic       clk,
    input  logic       reset,
    serial_rx_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic             r_sync1;
    logic             r_rs;
    logic             r_rs_prev;
    logic [1:0]       r_mode;
    logic [CNT_W-1:0] r_timer;
    logic [2:0]       r_idx;
    logic [7:0]       r_shreg;
    logic [7:0]       r_rx_data;
    logic             r_rx_valid;
    logic             r_frame_err;
    logic             r_overrun;

    logic [CNT_W-1:0] w_bit_new;
    logic [CNT_W-1:0] w_half_new;
    logic [CNT_W-1:0] w_bit_cur;
    logic             w_fall;
    logic             w_tmr_zero;
    logic             w_start;
    logic             w_first_sample;
    logic             w_sample_data;
    logic             w_complete;
    logic             w_stop_bad;
    logic             w_busy;

    // Bit period for a frame about to start uses the live mode; mid-frame reloads use the latched copy
    assign w_bit_new  = CNT_W'(BAUD_DIV) << bus.mode;
    assign w_half_new = w_bit_new >> 1;
    assign w_bit_cur  = CNT_W'(BAUD_DIV) << r_mode;
    assign w_fall     = r_rs_prev & ~r_rs;
    assign w_tmr_zero = (r_timer == '0);

    // Two-flop synchroniser plus previous-sample flop for falling-edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1   <= 1'b1;
            r_rs      <= 1'b1;
            r_rs_prev <= 1'b1;
        end else begin
            r_sync1   <= bus.rxd;
            r_rs      <= r_sync1;
            r_rs_prev <= r_rs;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; every sampling decision happens when the bit timer reaches zero
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:      if (w_fall) w_state_next = S_START;
            S_START:     if (w_tmr_zero) w_state_next = r_rs ? S_IDLE : S_DATA;
            S_DATA:      if (w_tmr_zero && (r_idx == 3'd7)) w_state_next = S_STOP;
            S_STOP:      if (w_tmr_zero) w_state_next = r_rs ? S_IDLE : S_WAIT_HIGH;
            S_WAIT_HIGH: if (r_rs) w_state_next = S_IDLE;
            default:     w_state_next = S_IDLE;
        endcase
    end

    // State-decoded strobes driving the datapath and the busy flag
    always_comb begin
        w_start        = (r_state == S_IDLE) && w_fall;
        w_first_sample = (r_state == S_START) && w_tmr_zero;
        w_sample_data  = (r_state == S_DATA) && w_tmr_zero;
        w_complete     = (r_state == S_STOP) && w_tmr_zero && r_rs;
        w_stop_bad     = (r_state == S_STOP) && w_tmr_zero && !r_rs;
        w_busy         = (r_state != S_IDLE);
    end

    // Bit timer, mode latch, bit index and shift register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_timer <= '0;
            r_mode  <= '0;
            r_idx   <= '0;
            r_shreg <= '0;
        end else begin
            if (w_start) begin
                r_timer <= w_half_new - CNT_W'(1);
                r_mode  <= bus.mode;
            end else if ((r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP)) begin
                r_timer <= w_tmr_zero ? (w_bit_cur - CNT_W'(1)) : (r_timer - CNT_W'(1));
            end
            if (w_first_sample) begin
                r_idx <= '0;
            end else if (w_sample_data) begin
                r_idx <= r_idx + 3'd1;
            end
            if (w_sample_data) begin
                r_shreg <= {r_rs, r_shreg[7:1]};
            end
        end
    end

    // Output byte, handshake flags and the framing-error pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_stop_bad;
            if (w_complete) begin
                r_rx_data  <= r_shreg;
                r_rx_valid <= 1'b1;
                // An ack landing on the completion edge consumes the old byte, so no overrun
                if (bus.ack) begin
                    r_overrun <= 1'b0;
                end else if (r_rx_valid) begin
                    r_overrun <= 1'b1;
                end
            end else if (bus.ack && r_rx_valid) begin
                r_rx_valid <= 1'b0;
                r_overrun  <= 1'b0;
            end
        end
    end

    assign bus.rx_data   = r_rx_data;
    assign bus.rx_valid  = r_rx_valid;
    assign bus.frame_err = r_frame_err;
    assign bus.overrun   = r_overrun;
    assign bus.busy      = w_busy;

endmodule

// File: tb/tb_serial_rx.sv
// Bench for serial_rx: frame-level reference model compared every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_serial_rx;

    localparam int BD = 8;

    logic       clk;
    logic       reset;
    logic [1:0] tb_mode;
    logic       tb_rxd;
    logic       tb_ack;

    int tests;
    int fails;
    int busy_cnt;
    int ferr_cnt;

    serial_rx_if bus ();

    assign bus.mode = tb_mode;
    assign bus.rxd  = tb_rxd;
    assign bus.ack  = tb_ack;

    serial_rx #(.BAUD_DIV(BD), .CNT_W(14)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: after a detected start edge at edge s, bits are sampled at
    // s + HALF + k*BIT (k = 0 start, 1..8 data LSB first, 9 stop), using the line
    // value two edges earlier.
    logic       m_d1, m_d2, m_d3;
    logic       m_active, m_wait, m_comp, m_rs, m_rsp;
    int         m_cyc, m_s, m_bit, m_half, m_off, m_k;
    logic [7:0] m_sh;
    logic [7:0] m_data;
    logic       m_valid, m_over, m_ferr, m_busy;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_d1 = 1'b1; m_d2 = 1'b1; m_d3 = 1'b1;
            m_active = 1'b0; m_wait = 1'b0;
            m_data = 8'h00; m_valid = 1'b0; m_over = 1'b0; m_ferr = 1'b0; m_busy = 1'b0;
        end else begin
            m_rs   = m_d2;
            m_rsp  = m_d3;
            m_comp = 1'b0;
            m_ferr = 1'b0;
            if (m_active) begin
                m_off = m_cyc - m_s;
                if (m_off >= m_half && ((m_off - m_half) % m_bit) == 0) begin
                    m_k = (m_off - m_half) / m_bit;
                    if (m_k == 0) begin
                        if (m_rs) m_active = 1'b0;
                    end else if (m_k <= 8) begin
                        m_sh[m_k-1] = m_rs;
                    end else begin
                        m_active = 1'b0;
                        if (m_rs) m_comp = 1'b1;
                        else begin
                            m_ferr = 1'b1;
                            m_wait = 1'b1;
                        end
                    end
                end
            end else if (m_wait) begin
                if (m_rs) m_wait = 1'b0;
            end else if (!m_rs && m_rsp) begin
                m_active = 1'b1;
                m_s      = m_cyc;
                m_bit    = BD << bus.mode;
                m_half   = m_bit / 2;
            end
            if (m_comp) begin
                if (bus.ack) m_over = 1'b0;
                else if (m_valid) m_over = 1'b1;
                m_valid = 1'b1;
                m_data  = m_sh;
            end else if (bus.ack && m_valid) begin
                m_valid = 1'b0;
                m_over  = 1'b0;
            end
            m_busy = m_active || m_wait;
            m_d3 = m_d2; m_d2 = m_d1; m_d1 = bus.rxd;
            m_cyc++;
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        check("cyc_rx_data", {24'h0, bus.rx_data}, {24'h0, m_data});
        check("cyc_rx_valid", {31'h0, bus.rx_valid}, {31'h0, m_valid});
        check("cyc_overrun", {31'h0, bus.overrun}, {31'h0, m_over});
        check("cyc_frame_err", {31'h0, bus.frame_err}, {31'h0, m_ferr});
        check("cyc_busy", {31'h0, bus.busy}, {31'h0, m_busy});
        if (bus.busy) busy_cnt++;
        if (bus.frame_err) ferr_cnt++;
    end

    task automatic send_frame(input logic [7:0] b, input logic stopb, input int bitlen);
        logic [9:0] f;
        f = {stopb, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            tb_rxd = f[i];
            repeat (bitlen) @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.rx_valid && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 2000) check("valid_timeout", 32'd1, 32'd0);
    endtask

    task automatic ack_pulse();
        tb_ack = 1'b1;
        @(posedge clk);
        #1;
        tb_ack = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int n;
    int b0;
    int f0;

    initial begin
        tests = 0; fails = 0; busy_cnt = 0; ferr_cnt = 0;
        m_cyc = 0; m_s = 0; m_bit = BD; m_half = BD / 2; m_off = 0; m_k = 0; m_sh = 8'h00;
        reset = 1'b0; tb_rxd = 1'b1; tb_ack = 1'b0; tb_mode = 2'd0;
        idle(3);
        check("rst_rx_data", {24'h0, bus.rx_data}, 32'h00);
        check("rst_rx_valid", {31'h0, bus.rx_valid}, 32'h0);
        check("rst_overrun", {31'h0, bus.overrun}, 32'h0);
        check("rst_frame_err", {31'h0, bus.frame_err}, 32'h0);
        check("rst_busy", {31'h0, bus.busy}, 32'h0);
        reset = 1'b1;
        idle(10);

        // 1: mode 0, 0x38, latency 2 + 4 + 72 (+/-1)
        fork
            send_frame(8'h38, 1'b1, BD);
            wait_valid(n);
        join
        tests++;
        if (n < 77 || n > 79) begin
            fails++;
            $display("FAIL t1_latency: got %0d clk, expected 77..79", n);
        end
        check("t1_rx_data", {24'h0, bus.rx_data}, 32'h38);
        ack_pulse();
        check("t1_valid_after_ack", {31'h0, bus.rx_valid}, 32'h0);
        idle(5);

        // 2: mode 2 (BIT=32), mode dropped to 0 mid-frame
        tb_mode = 2'd2;
        fork
            send_frame(8'h96, 1'b1, 32);
            begin
                idle(20);
                tb_mode = 2'd0;
            end
        join
        idle(5);
        check("t2_rx_data", {24'h0, bus.rx_data}, 32'h96);
        check("t2_rx_valid", {31'h0, bus.rx_valid}, 32'h1);
        ack_pulse();
        idle(5);

        // 3: 3-clk glitch is rejected; busy only for HALF = 4 clk
        b0 = busy_cnt;
        tb_rxd = 1'b0;
        idle(3);
        tb_rxd = 1'b1;
        idle(20);
        check("t3_busy_cycles", busy_cnt - b0, 32'd4);
        check("t3_rx_valid", {31'h0, bus.rx_valid}, 32'h0);
        check("t3_rx_data", {24'h0, bus.rx_data}, 32'h96);

        // 4: bad stop bit, line held low, then a good frame
        f0 = ferr_cnt;
        send_frame(8'h48, 1'b0, BD);
        idle(40);
        tb_rxd = 1'b1;
        idle(20);
        check("t4_frame_err_pulses", ferr_cnt - f0, 32'd1);
        check("t4_rx_data_kept", {24'h0, bus.rx_data}, 32'h96);
        check("t4_rx_valid_kept", {31'h0, bus.rx_valid}, 32'h0);
        fork
            send_frame(8'h19, 1'b1, BD);
            wait_valid(n);
        join
        check("t4_next_rx_data", {24'h0, bus.rx_data}, 32'h19);
        ack_pulse();
        idle(5);

        // 5a: back-to-back frames without ack -> overrun
        send_frame(8'h11, 1'b1, BD);
        send_frame(8'h22, 1'b1, BD);
        idle(10);
        check("t5_rx_data", {24'h0, bus.rx_data}, 32'h22);
        check("t5_rx_valid", {31'h0, bus.rx_valid}, 32'h1);
        check("t5_overrun", {31'h0, bus.overrun}, 32'h1);
        ack_pulse();
        check("t5_valid_cleared", {31'h0, bus.rx_valid}, 32'h0);
        check("t5_overrun_cleared", {31'h0, bus.overrun}, 32'h0);
        idle(5);

        // 5b: ack lands on the completion edge of the second frame
        send_frame(8'h11, 1'b1, BD);
        fork
            send_frame(8'h22, 1'b1, BD);
            begin
                idle(78);
                tb_ack = 1'b1;
                @(posedge clk);
                #1;
                tb_ack = 1'b0;
            end
        join
        idle(5);
        check("t5b_rx_data", {24'h0, bus.rx_data}, 32'h22);
        check("t5b_rx_valid", {31'h0, bus.rx_valid}, 32'h1);
        check("t5b_overrun", {31'h0, bus.overrun}, 32'h0);
        ack_pulse();
        idle(5);

        // 6: reset during data bit 4, then a fresh frame
        fork
            send_frame(8'h5A, 1'b1, BD);
            begin
                repeat (42) @(posedge clk);
                #2;
                reset = 1'b0;
                #1;
                check("t6_rst_rx_data", {24'h0, bus.rx_data}, 32'h00);
                check("t6_rst_rx_valid", {31'h0, bus.rx_valid}, 32'h0);
                check("t6_rst_overrun", {31'h0, bus.overrun}, 32'h0);
                check("t6_rst_frame_err", {31'h0, bus.frame_err}, 32'h0);
                check("t6_rst_busy", {31'h0, bus.busy}, 32'h0);
            end
        join
        tb_rxd = 1'b1;
        idle(3);
        reset = 1'b1;
        idle(10);
        fork
            send_frame(8'h5A, 1'b1, BD);
            wait_valid(n);
        join
        check("t6_rx_data", {24'h0, bus.rx_data}, 32'h5A);
        check("t6_rx_valid", {31'h0, bus.rx_valid}, 32'h1);
        idle(10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
